// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: single-outstanding load/store initiator for a simple SRAM
// request/response bus, with lane steering, extension, strobes and a timeout guard.
`default_nettype none

module lsu_mem_initiator #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1023
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic                    ren,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rvalid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic                    wen,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [1:0]              bresp,
    input  logic                    bvalid
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_WRITE   = 3'd2,
        S_RELEASE = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [1:0]              off_q, off_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic                    req_ready_q, req_ready_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic                    resp_err_q, resp_err_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]           wstrb_q, wstrb_d;
    logic                    ren_q, ren_d;
    logic                    wen_q, wen_d;

    logic                    w_misal;
    logic [SW-1:0]           w_strb_base;
    logic [DATA_WIDTH-1:0]   w_lane;
    logic [DATA_WIDTH-1:0]   w_load_fmt;

    assign w_misal = (req_size == 2'd3) ||
                     ((req_size == 2'd1) && req_addr[0]) ||
                     ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

    assign w_strb_base = (req_size == 2'd0) ? SW'(4'b0001) :
                         (req_size == 2'd1) ? SW'(4'b0011) : SW'(4'b1111);

    assign w_lane = rdata >> {off_q, 3'b000};

    always_comb begin
        w_load_fmt = w_lane;
        case (size_q)
            2'd0: w_load_fmt = uns_q ? {{(DATA_WIDTH-8){1'b0}}, w_lane[7:0]}
                                     : {{(DATA_WIDTH-8){w_lane[7]}}, w_lane[7:0]};
            2'd1: w_load_fmt = uns_q ? {{(DATA_WIDTH-16){1'b0}}, w_lane[15:0]}
                                     : {{(DATA_WIDTH-16){w_lane[15]}}, w_lane[15:0]};
            default: w_load_fmt = rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        araddr_d     = araddr_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        ren_d        = ren_q;
        wen_d        = wen_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    off_d       = req_addr[1:0];
                    size_d      = req_size;
                    uns_d       = req_unsigned;
                    cnt_d       = '0;
                    req_ready_d = 1'b0;
                    if (w_misal) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                        state_d      = S_RESP;
                    end else if (req_wen) begin
                        awaddr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        wdata_d  = req_wdata << {req_addr[1:0], 3'b000};
                        wstrb_d  = w_strb_base << req_addr[1:0];
                        wen_d    = 1'b1;
                        state_d  = S_WRITE;
                    end else begin
                        araddr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        ren_d    = 1'b1;
                        state_d  = S_READ;
                    end
                end
            end
            S_READ: begin
                if (rvalid) begin
                    ren_d        = 1'b0;
                    resp_err_d   = (rresp != 2'b00);
                    resp_rdata_d = (rresp != 2'b00) ? '0 : w_load_fmt;
                    state_d      = S_RELEASE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    ren_d        = 1'b0;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                    state_d      = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WRITE: begin
                if (bvalid) begin
                    wen_d        = 1'b0;
                    resp_err_d   = (bresp != 2'b00);
                    resp_rdata_d = '0;
                    state_d      = S_RELEASE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    wen_d        = 1'b0;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = '0;
                    state_d      = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            // Wait for the responder to see the request drop before answering.
            S_RELEASE: begin
                if (!rvalid && !bvalid) begin
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d      = S_IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                ren_d        = 1'b0;
                wen_d        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            off_q        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            araddr_q     <= '0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            ren_q        <= 1'b0;
            wen_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            araddr_q     <= araddr_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            ren_q        <= ren_d;
            wen_q        <= wen_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign araddr     = araddr_q;
    assign awaddr     = awaddr_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign ren        = ren_q;
    assign wen        = wen_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: directed bench with a transaction-level model, an SRAM
// responder and a per-cycle compare process.
`default_nettype none

module tb_lsu_mem_initiator;

    localparam int TO = 8;

    logic        clk, rst;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic        ren, wen, rvalid, bvalid;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    lsu_mem_initiator #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .araddr(araddr), .ren(ren), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
        .awaddr(awaddr), .wdata(wdata), .wen(wen), .wstrb(wstrb),
        .bresp(bresp), .bvalid(bvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Responder configuration
    int          sram_delay = 0;
    bit          sram_never = 0;
    logic [31:0] sram_rdata = '0;
    logic [1:0]  sram_resp  = '0;

    // Model expectations for the current transaction
    bit          exp_misal, exp_store;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_wstrb;
    logic        exp_err;

    int          ren_cycles, wen_cycles;
    logic [31:0] last_araddr, last_awaddr, last_wdata, last_wstrb;
    logic [31:0] got_rdata;
    logic        got_err;
    bit          chk_en = 0;

    function automatic void model(input bit st, input logic [31:0] a, input logic [1:0] sz,
                                  input bit uns, input logic [31:0] wd,
                                  input logic [31:0] srd, input logic [1:0] sresp, input bit never);
        int          off, nb;
        logic [63:0] wide;
        logic [31:0] lane, mask, val;
        off       = int'(a % 4);
        nb        = (sz == 2'd3) ? 0 : (1 << sz);
        exp_store = st;
        exp_misal = (sz == 2'd3) || ((off % nb) != 0);
        exp_addr  = a - 32'(off);
        wide      = {32'b0, wd} << (8 * off);
        exp_wdata = wide[31:0];
        exp_wstrb = (nb == 0) ? 4'b0 : 4'(((1 << nb) - 1) << off);
        lane      = srd >> (8 * off);
        mask      = (nb >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        val       = lane & mask;
        if (!uns && nb > 0 && nb < 4 && lane[8*nb-1]) val = val | ~mask;
        exp_err   = exp_misal || never || (sresp != 2'b00);
        exp_rdata = (st || exp_err) ? 32'h0 : val;
    endfunction

    // SRAM responder: raises valid after sram_delay cycles, drops it once it sees the request low
    initial begin : responder
        int cnt;
        rvalid = 0; bvalid = 0; rdata = '0; rresp = '0; bresp = '0; cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rvalid = 0; bvalid = 0; cnt = 0;
            end else if (ren || wen) begin
                if (!rvalid && !bvalid) begin
                    if (!sram_never && cnt >= sram_delay) begin
                        if (ren) begin rvalid = 1; rdata = sram_rdata; rresp = sram_resp; end
                        else     begin bvalid = 1; bresp = sram_resp; end
                    end else begin
                        cnt++;
                    end
                end
            end else begin
                rvalid = 0; bvalid = 0; cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            check("ren_wen_exclusive", {31'b0, ren & wen}, 32'h0);
            if (ren) begin
                ren_cycles++;
                last_araddr = araddr;
                check("araddr", araddr, exp_addr);
                check("ren_only_for_load", {31'b0, exp_store | exp_misal}, 32'h0);
            end
            if (wen) begin
                wen_cycles++;
                last_awaddr = awaddr; last_wdata = wdata; last_wstrb = {28'b0, wstrb};
                check("awaddr", awaddr, exp_addr);
                check("wdata", wdata, exp_wdata);
                check("wstrb", {28'b0, wstrb}, {28'b0, exp_wstrb});
                check("wen_only_for_store", {31'b0, exp_store & ~exp_misal}, 32'h1);
            end
            if (resp_valid) begin
                check("resp_rdata", resp_rdata, exp_rdata);
                check("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
                check("resp_after_valid_low", {30'b0, rvalid, bvalid}, 32'h0);
            end
            if (req_ready) check("idle_outputs", {29'b0, ren, wen, resp_valid}, 32'h0);
        end
    end

    task automatic start_req(input bit st, input logic [31:0] a, input logic [1:0] sz,
                             input bit uns, input logic [31:0] wd, input logic [31:0] srd,
                             input logic [1:0] sresp, input int dly, input bit never);
        int n;
        sram_rdata = srd; sram_resp = sresp; sram_delay = dly; sram_never = never;
        model(st, a, sz, uns, wd, srd, sresp, never);
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        check("req_ready_before_issue", {31'b0, req_ready}, 32'h1);
        ren_cycles = 0; wen_cycles = 0;
        req_wen = st; req_addr = a; req_size = sz; req_unsigned = uns; req_wdata = wd;
        req_valid = 1;
        @(posedge clk);
        #1 req_valid = 0;
    endtask

    task automatic finish_resp(input int hold);
        int lat;
        resp_ready = (hold == 0);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!resp_valid && lat < 40);
        check("resp_valid_seen", {31'b0, resp_valid}, 32'h1);
        got_rdata = resp_rdata; got_err = resp_err;
        check("bus_cycles", 32'(ren_cycles + wen_cycles),
              exp_misal ? 32'h0 : (sram_never ? 32'(TO) : 32'(sram_delay + 1)));
        check("latency", 32'(lat), exp_misal ? 32'h1 : 32'(ren_cycles + wen_cycles + 2));
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check("resp_held", {31'b0, resp_valid}, 32'h1);
            resp_ready = 1;
        end
        @(posedge clk);
        @(negedge clk);
        check("resp_dropped", {31'b0, resp_valid}, 32'h0);
        check("ready_after_resp", {31'b0, req_ready}, 32'h1);
    endtask

    initial begin
        rst = 1; req_valid = 0; req_wen = 0; req_addr = '0; req_wdata = '0;
        req_size = '0; req_unsigned = 0; resp_ready = 1;
        ren_cycles = 0; wen_cycles = 0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'h1);
        check("rst_outputs", {27'b0, resp_valid, resp_err, ren, wen, |wstrb}, 32'h0);
        check("rst_araddr", araddr, 32'h0);
        check("rst_rdata", resp_rdata, 32'h0);
        rst = 0;
        chk_en = 1;
        @(negedge clk);

        // Signed byte load from the top lane
        start_req(0, 32'h8000_0003, 2'd0, 0, 32'h0, 32'h80FF_1234, 2'd0, 2, 0);
        finish_resp(0);
        check("pin_lb_rdata", got_rdata, 32'hFFFF_FF80);
        check("pin_lb_err", {31'b0, got_err}, 32'h0);
        check("pin_lb_araddr", last_araddr, 32'h8000_0000);
        check("pin_lb_ren_cycles", 32'(ren_cycles), 32'd3);

        // Unsigned half load, response held off for two cycles
        start_req(0, 32'h8000_0002, 2'd1, 1, 32'h0, 32'hBEEF_0000, 2'd0, 0, 0);
        finish_resp(2);
        check("pin_lhu_rdata", got_rdata, 32'h0000_BEEF);

        // Byte store into lane 1
        start_req(1, 32'h8000_0001, 2'd0, 0, 32'h0000_00AB, 32'h0, 2'd0, 1, 0);
        finish_resp(0);
        check("pin_sb_awaddr", last_awaddr, 32'h8000_0000);
        check("pin_sb_wdata", last_wdata, 32'h0000_AB00);
        check("pin_sb_wstrb", last_wstrb, 32'h2);
        check("pin_sb_resp", {got_rdata[30:0], got_err}, 32'h0);

        // Misaligned and reserved-size requests never touch the bus
        start_req(0, 32'h8000_0002, 2'd2, 0, 32'h0, 32'h1234_5678, 2'd0, 0, 0);
        finish_resp(0);
        check("pin_misal_word_err", {31'b0, got_err}, 32'h1);
        start_req(1, 32'h8000_0001, 2'd1, 0, 32'h0000_5555, 32'h0, 2'd0, 0, 0);
        finish_resp(0);
        check("pin_misal_half_err", {31'b0, got_err}, 32'h1);
        start_req(0, 32'h8000_0000, 2'd3, 0, 32'h0, 32'h0, 2'd0, 0, 0);
        finish_resp(0);

        // Back-to-back store then signed half load, zero SRAM delay
        start_req(1, 32'h8000_0010, 2'd2, 0, 32'h1122_3344, 32'h0, 2'd0, 0, 0);
        finish_resp(0);
        check("pin_sw_wstrb", last_wstrb, 32'hF);
        start_req(0, 32'h8000_0012, 2'd1, 0, 32'h0, 32'h8001_7777, 2'd0, 0, 0);
        finish_resp(0);
        check("pin_lh_rdata", got_rdata, 32'hFFFF_8001);

        // Error responses from the SRAM
        start_req(0, 32'h8000_0004, 2'd2, 0, 32'h0, 32'hCAFE_F00D, 2'd2, 1, 0);
        finish_resp(0);
        check("pin_rresp_err", {got_rdata[30:0], got_err}, 32'h1);
        start_req(1, 32'h8000_0002, 2'd1, 0, 32'h0000_ABCD, 32'h0, 2'd1, 0, 0);
        finish_resp(0);
        check("pin_bresp_wdata", last_wdata, 32'hABCD_0000);

        // Unsigned byte from lane 2
        start_req(0, 32'h8000_0006, 2'd0, 1, 32'h0, 32'h00F0_0000, 2'd0, 3, 0);
        finish_resp(0);
        check("pin_lbu_rdata", got_rdata, 32'h0000_00F0);

        // Responder never answers: timeout
        start_req(0, 32'h8000_0008, 2'd2, 0, 32'h0, 32'h0, 2'd0, 0, 1);
        finish_resp(0);
        check("pin_timeout_err", {31'b0, got_err}, 32'h1);
        check("pin_timeout_cycles", 32'(ren_cycles), 32'd8);

        // Reset in the middle of a read
        start_req(0, 32'h8000_0000, 2'd2, 0, 32'h0, 32'h0, 2'd0, 0, 1);
        repeat (3) @(negedge clk);
        check("pre_rst_ren", {31'b0, ren}, 32'h1);
        #2 rst = 1;
        #1;
        check("async_rst_ren", {31'b0, ren}, 32'h0);
        check("async_rst_ready", {31'b0, req_ready}, 32'h1);
        check("async_rst_resp", {31'b0, resp_valid}, 32'h0);
        @(negedge clk);
        rst = 0;
        sram_never = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_resp_after_abort", {30'b0, resp_valid, ren}, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
